// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, reset polarity and write-source encoding for the regfile
// write-port arbiter and its busy scoreboard.
package wb_port_arbiter_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int REG_NUM      = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Reset is asserted when rst is low.
  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic {
    WB_SRC_PL = 1'b0,
    WB_SRC_AX = 1'b1
  } wb_src_e;

  // Width needed to hold 0..limit inclusive.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy bitmap of destinations with an outstanding aux result; register 0 is
// never marked. A new issue to the same register outranks a retiring one.
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_BUS,
  parameter int REG_N  = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              busy1,
  output logic              busy2
);

  logic [REG_N-1:0] bits;
  logic [REG_N-1:0] bits_nxt;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    bits_nxt = bits;
    if (clr && (int'(clr_addr) < REG_N)) begin
      bits_nxt[clr_addr] = 1'b0;
    end
    if (set && (set_addr != '0) && (int'(set_addr) < REG_N)) begin
      bits_nxt[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the bitmap is state ID stalls on, so it must come out of reset clear; a plain data array would not need reset.
    if (rst == RST_ENABLE) begin
      bits <= '0;
    end else begin
      bits <= bits_nxt;
    end
  end

  assign busy1 = (int'(chk_addr1) < REG_N) ? bits[chk_addr1] : 1'b0;
  assign busy2 = (int'(chk_addr2) < REG_N) ? bits[chk_addr2] : 1'b0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port between the WB stage and the aux
// long-latency result path, with starvation relief for aux.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = REG_BUS,
  parameter int ADDR_W       = REG_ADDR_BUS,
  parameter int REG_N        = REG_NUM,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pl_we,
  input  logic [ADDR_W-1:0] pl_waddr,
  input  logic [DATA_W-1:0] pl_wdata,
  output logic              pl_ready,
  input  logic              ax_valid,
  input  logic [ADDR_W-1:0] ax_waddr,
  input  logic [DATA_W-1:0] ax_wdata,
  output logic              ax_ready,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic [ADDR_W-1:0] sb_chk_addr1,
  input  logic [ADDR_W-1:0] sb_chk_addr2,
  output logic              sb_busy1,
  output logic              sb_busy2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             grant;
  wb_src_e          src;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  // Aux wins when it is alone or when it has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant = 1'b0;
    src   = WB_SRC_PL;
    if (rst != RST_ENABLE) begin
      if (ax_valid && (!pl_we || (starve_cnt >= LIMIT))) begin
        grant = 1'b1;
        src   = WB_SRC_AX;
      end else if (pl_we) begin
        grant = 1'b1;
      end
    end
  end

  assign pl_ready   = grant && (src == WB_SRC_PL);
  assign ax_ready   = grant && (src == WB_SRC_AX);
  assign grant_addr = (src == WB_SRC_AX) ? ax_waddr : pl_waddr;
  assign grant_data = (src == WB_SRC_AX) ? ax_wdata : pl_wdata;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst == RST_ENABLE) begin
      starve_cnt <= '0;
    end else if (ax_ready) begin
      starve_cnt <= '0;
    end else if (ax_valid && pl_ready && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Writes to register 0 are accepted upstream but never reach the regfile.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant) begin
      rf_we    <= (grant_addr != '0);
      rf_waddr <= grant_addr;
      rf_wdata <= grant_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .REG_N  (REG_N)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set       (sb_set),
    .set_addr  (sb_set_addr),
    .clr       (ax_ready),
    .clr_addr  (ax_waddr),
    .chk_addr1 (sb_chk_addr1),
    .chk_addr2 (sb_chk_addr2),
    .busy1     (sb_busy1),
    .busy2     (sb_busy2)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector table for the arbiter corner cases, then randomized traffic
// against a behavioural model of grant, starvation, scoreboard and write port.
module tb_wb_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pl_we, ax_valid, sb_set;
  logic [AW-1:0] pl_waddr, ax_waddr, sb_set_addr, sb_chk_addr1, sb_chk_addr2;
  logic [DW-1:0] pl_wdata, ax_wdata;
  logic          pl_ready, ax_ready, sb_busy1, sb_busy2, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W (DW), .ADDR_W (AW), .REG_N (NR), .STARVE_LIMIT (LIM)
  ) dut (
    .clk (clk), .rst (rst),
    .pl_we (pl_we), .pl_waddr (pl_waddr), .pl_wdata (pl_wdata), .pl_ready (pl_ready),
    .ax_valid (ax_valid), .ax_waddr (ax_waddr), .ax_wdata (ax_wdata), .ax_ready (ax_ready),
    .sb_set (sb_set), .sb_set_addr (sb_set_addr),
    .sb_chk_addr1 (sb_chk_addr1), .sb_chk_addr2 (sb_chk_addr2),
    .sb_busy1 (sb_busy1), .sb_busy2 (sb_busy2),
    .rf_we (rf_we), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata)
  );

  // One cycle of stimulus plus the expected outputs; rf expectations are
  // observed just after the edge that ends the cycle.
  typedef struct {
    logic [31:0] rst, pl_we, pl_waddr, pl_wdata;
    logic [31:0] ax_valid, ax_waddr, ax_wdata;
    logic [31:0] sb_set, sb_set_addr, chk1, chk2;
    logic [31:0] e_pl, e_ax, e_b1, e_b2, e_we, e_waddr, e_wdata, chk_data;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model state.
  int          m_lost = 0;
  bit          m_busy [NR];
  logic        m_we = 1'b0;
  logic [31:0] m_waddr = '0;
  logic [31:0] m_wdata = '0;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input vec_t t);
    tbl.push_back(t);
  endtask

  task automatic run(input vec_t t, input bit use_tbl, input int row);
    logic        ar, pr;
    logic [31:0] gaddr, gdata;
    rst          = t.rst[0];
    pl_we        = t.pl_we[0];
    pl_waddr     = t.pl_waddr[AW-1:0];
    pl_wdata     = t.pl_wdata;
    ax_valid     = t.ax_valid[0];
    ax_waddr     = t.ax_waddr[AW-1:0];
    ax_wdata     = t.ax_wdata;
    sb_set       = t.sb_set[0];
    sb_set_addr  = t.sb_set_addr[AW-1:0];
    sb_chk_addr1 = t.chk1[AW-1:0];
    sb_chk_addr2 = t.chk2[AW-1:0];
    #1;
    if (!t.rst[0]) begin
      ar = 1'b0;
      pr = 1'b0;
    end else begin
      ar = t.ax_valid[0] && (!t.pl_we[0] || m_lost >= LIM);
      pr = t.pl_we[0] && !ar;
    end
    if (t.pl_we[0] || !t.rst[0])
      check("pl_ready", row, 32'(pl_ready), use_tbl ? t.e_pl : 32'(pr));
    check("ax_ready", row, 32'(ax_ready), use_tbl ? t.e_ax : 32'(ar));
    check("sb_busy1", row, 32'(sb_busy1), use_tbl ? t.e_b1 : 32'(m_busy[t.chk1[AW-1:0]]));
    check("sb_busy2", row, 32'(sb_busy2), use_tbl ? t.e_b2 : 32'(m_busy[t.chk2[AW-1:0]]));
    @(posedge clk);
    if (!t.rst[0]) begin
      m_lost = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      gaddr = ar ? t.ax_waddr : t.pl_waddr;
      gdata = ar ? t.ax_wdata : t.pl_wdata;
      if (ar || pr) begin
        m_we = (gaddr != 0); m_waddr = gaddr; m_wdata = gdata;
      end else begin
        m_we = 1'b0;
      end
      if (ar) m_lost = 0;
      else if (t.ax_valid[0] && pr && m_lost < LIM) m_lost = m_lost + 1;
      if (ar) m_busy[t.ax_waddr[AW-1:0]] = 1'b0;
      if (t.sb_set[0] && t.sb_set_addr != 0) m_busy[t.sb_set_addr[AW-1:0]] = 1'b1;
    end
    #1;
    check("rf_we", row, 32'(rf_we), use_tbl ? t.e_we : 32'(m_we));
    if (use_tbl ? t.chk_data[0] : m_we) begin
      check("rf_waddr", row, 32'(rf_waddr), use_tbl ? t.e_waddr : m_waddr);
      check("rf_wdata", row, rf_wdata, use_tbl ? t.e_wdata : m_wdata);
    end
  endtask

  initial begin
    vec_t r;
    //    rst pw pa pd            av aa ad            ss sa c1 c2  epl eax eb1 eb2 ewe ewa ewd           cd
    // Reset held with both requesters active.
    add('{0, 1, 3, 32'h1,        1, 4, 32'h2,        0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0,        1});
    add('{0, 1, 3, 32'h1,        1, 4, 32'h2,        0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0,        1});
    // Lone WB write.
    add('{1, 1, 3, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 0, 0,  1, 0, 0, 0, 1, 3, 32'hDEADBEEF, 1});
    // Six cycles of contention: four WB wins, one forced aux, then WB again.
    add('{1, 1, 5, 32'hA1,       1, 6, 32'hB0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hA1,       1});
    add('{1, 1, 5, 32'hA2,       1, 6, 32'hB0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hA2,       1});
    add('{1, 1, 5, 32'hA3,       1, 6, 32'hB0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hA3,       1});
    add('{1, 1, 5, 32'hA4,       1, 6, 32'hB0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hA4,       1});
    add('{1, 1, 5, 32'hA5,       1, 6, 32'hB0,       0, 0, 0, 0,  0, 1, 0, 0, 1, 6, 32'hB0,       1});
    add('{1, 1, 5, 32'hA6,       1, 6, 32'hB0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hA6,       1});
    // Scoreboard set on 7, then retire an aux write to 7.
    add('{1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 7, 7, 0,  0, 0, 0, 0, 0, 5, 32'hA6,       1});
    add('{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 7, 0,  0, 0, 1, 0, 0, 5, 32'hA6,       1});
    add('{1, 0, 0, 32'h0,        1, 7, 32'h77,       0, 0, 7, 0,  0, 1, 1, 0, 1, 7, 32'h77,       1});
    add('{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 7, 0,  0, 0, 0, 0, 0, 7, 32'h77,       1});
    // Set and retire 9 in the same cycle: set wins. Setting 0 has no effect.
    add('{1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 0, 9,  0, 0, 0, 0, 0, 7, 32'h77,       1});
    add('{1, 0, 0, 32'h0,        1, 9, 32'h99,       1, 9, 0, 9,  0, 1, 0, 1, 1, 9, 32'h99,       1});
    add('{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 9,  0, 0, 0, 1, 0, 9, 32'h99,       1});
    add('{1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 9,  0, 0, 0, 1, 0, 9, 32'h99,       1});
    add('{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 9,  0, 0, 0, 1, 0, 9, 32'h99,       1});
    // Writes to register 0 are accepted but suppressed.
    add('{1, 1, 0, 32'h1234,     0, 0, 32'h0,        0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 32'h0,        0});
    add('{1, 0, 0, 32'h0,        1, 0, 32'h55,       0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 32'h0,        0});
    // Two aux losses, then reset mid-starvation must restart the count.
    add('{1, 1, 5, 32'hC1,       1, 6, 32'hD0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hC1,       1});
    add('{1, 1, 5, 32'hC2,       1, 6, 32'hD0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hC2,       1});
    add('{0, 1, 5, 32'hC3,       1, 6, 32'hD0,       0, 0, 0, 9,  0, 0, 0, 1, 0, 0, 32'h0,        1});
    add('{1, 1, 5, 32'hE1,       1, 6, 32'hD0,       0, 0, 0, 9,  1, 0, 0, 0, 1, 5, 32'hE1,       1});
    add('{1, 1, 5, 32'hE2,       1, 6, 32'hD0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hE2,       1});
    add('{1, 1, 5, 32'hE3,       1, 6, 32'hD0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hE3,       1});
    add('{1, 1, 5, 32'hE4,       1, 6, 32'hD0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 32'hE4,       1});
    add('{1, 1, 5, 32'hE5,       1, 6, 32'hD0,       0, 0, 0, 0,  0, 1, 0, 0, 1, 6, 32'hD0,       1});

    foreach (tbl[i]) run(tbl[i], 1'b1, i);

    for (int i = 0; i < 400; i++) begin
      r = '{default: '0};
      r.rst         = ($urandom_range(0, 49) != 0) ? 32'd1 : 32'd0;
      r.pl_we       = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0;
      r.pl_waddr    = $urandom_range(0, 7);
      r.pl_wdata    = $urandom;
      r.ax_valid    = 32'($urandom_range(0, 1));
      r.ax_waddr    = $urandom_range(0, 7);
      r.ax_wdata    = $urandom;
      r.sb_set      = ($urandom_range(0, 2) == 0) ? 32'd1 : 32'd0;
      r.sb_set_addr = $urandom_range(0, 7);
      r.chk1        = $urandom_range(0, 7);
      r.chk2        = $urandom_range(0, 7);
      run(r, 1'b0, 1000 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
